// File: rtl/kalman_pkg.sv
// Shared constants, FSM state type and saturation limits for the Kalman matrix stages.
package kalman_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_NOS   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } add_state_t;

    // Limits are returned wide; callers truncate to their element width.
    function automatic logic [63:0] sat_max(input int width);
        sat_max = (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int width);
        sat_min = 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/elem_addsub.sv
// Single-element signed add/subtract with overflow flag.
// MAT_ADD_SAT_EN defined: overflowing results clamp; otherwise they wrap.
module elem_addsub
    import kalman_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] y,
    output logic             ovf
);

`ifdef MAT_ADD_SAT_EN
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(sat_min(WIDTH));
`endif

    logic [WIDTH:0] w_a_ext;
    logic [WIDTH:0] w_b_ext;
    logic [WIDTH:0] w_sum;

    // One guard bit is enough to hold the exact sum or difference.
    always_comb begin
        w_a_ext = {a[WIDTH-1], a};
        w_b_ext = {b[WIDTH-1], b};
        if (sub) begin
            w_sum = w_a_ext - w_b_ext;
        end else begin
            w_sum = w_a_ext + w_b_ext;
        end
        ovf = w_sum[WIDTH] ^ w_sum[WIDTH-1];
`ifdef MAT_ADD_SAT_EN
        if (ovf) begin
            y = w_sum[WIDTH] ? MIN_V : MAX_V;
        end else begin
            y = w_sum[WIDTH-1:0];
        end
`else
        y = w_sum[WIDTH-1:0];
`endif
    end

endmodule

// File: rtl/matrix_add_stage.sv
// Element-serial nos x nos matrix add/subtract stage with start/end handshake.
// Overflow handling is selected by MAT_ADD_SAT_EN inside elem_addsub.
module matrix_add_stage
    import kalman_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int nos   = DEF_NOS
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 startAdd,
    input  logic                                 subtract,
    input  logic [nos-1:0][nos-1:0][WIDTH-1:0]   A,
    input  logic [nos-1:0][nos-1:0][WIDTH-1:0]   B,
    output logic [nos-1:0][nos-1:0][WIDTH-1:0]   Res,
    output logic                                 endAdd,
    output logic                                 ovf
);

    localparam int NN   = nos * nos;
    localparam int IDXW = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NN - 1);

    add_state_t                   r_state;
    add_state_t                   w_next_state;
    logic                         r_start_q;
    logic [IDXW-1:0]              r_idx;
    // Flat row-major views: element idx = r*nos + c matches the packed port layout.
    logic [NN-1:0][WIDTH-1:0]     r_a_snap;
    logic [NN-1:0][WIDTH-1:0]     r_b_snap;
    logic                         r_sub_snap;
    logic [NN-1:0][WIDTH-1:0]     r_res;
    logic                         r_end_add;
    logic                         r_ovf;

    logic                         w_launch;
    logic                         w_write;
    logic                         w_last;
    logic [WIDTH-1:0]             w_elem_y;
    logic                         w_elem_ovf;

    elem_addsub #(.WIDTH(WIDTH)) u_elem (
        .a   (r_a_snap[r_idx]),
        .b   (r_b_snap[r_idx]),
        .sub (r_sub_snap),
        .y   (w_elem_y),
        .ovf (w_elem_ovf)
    );

    // State register and start-edge history.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_start_q <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_start_q <= startAdd;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_launch) w_next_state = RUN;
                else          w_next_state = IDLE;
            end
            RUN: begin
                if (w_last) w_next_state = DONE;
                else        w_next_state = RUN;
            end
            DONE: begin
                if (w_launch) w_next_state = RUN;
                else          w_next_state = DONE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Control decode; start edges during RUN are deliberately dropped.
    always_comb begin
        w_launch = 1'b0;
        w_write  = 1'b0;
        w_last   = 1'b0;
        case (r_state)
            IDLE, DONE: w_launch = startAdd & ~r_start_q;
            RUN: begin
                w_write = 1'b1;
                w_last  = (r_idx == LAST_IDX);
            end
            default: w_launch = 1'b0;
        endcase
    end

    // Operand snapshot, element index and result register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= '0;
            r_a_snap   <= '0;
            r_b_snap   <= '0;
            r_sub_snap <= 1'b0;
            r_res      <= '0;
            r_end_add  <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (w_launch) begin
            r_idx      <= '0;
            r_a_snap   <= A;
            r_b_snap   <= B;
            r_sub_snap <= subtract;
            r_end_add  <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (w_write) begin
            r_res[r_idx] <= w_elem_y;
            r_ovf        <= r_ovf | w_elem_ovf;
            if (w_last) begin
                r_end_add <= 1'b1;
            end else begin
                r_idx <= r_idx + IDXW'(1);
            end
        end
    end

    assign Res    = r_res;
    assign endAdd = r_end_add;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_matrix_add_stage.sv
// Directed + randomized self-checking bench for matrix_add_stage against an arithmetic reference model.
module tb_matrix_add_stage;

    localparam int W = 16;
    localparam int N = 4;

    typedef logic [N-1:0][N-1:0][W-1:0] mat_t;

    logic clk;
    logic rst;
    logic startAdd;
    logic subtract;
    mat_t A;
    mat_t B;
    mat_t Res;
    logic endAdd;
    logic ovf;

    int n_assert = 0;
    int n_fail   = 0;

    matrix_add_stage #(.WIDTH(W), .nos(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .startAdd (startAdd),
        .subtract (subtract),
        .A        (A),
        .B        (B),
        .Res      (Res),
        .endAdd   (endAdd),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Exact signed arithmetic per element, then wrap or clamp.
    function automatic void model(input mat_t a, input mat_t b, input logic sub,
                                  output mat_t res, output logic ov);
        ov  = 1'b0;
        res = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                int ex;
                if (sub) ex = int'($signed(a[r][c])) - int'($signed(b[r][c]));
                else     ex = int'($signed(a[r][c])) + int'($signed(b[r][c]));
                if (ex > 32767 || ex < -32768) begin
                    ov = 1'b1;
`ifdef MAT_ADD_SAT_EN
                    res[r][c] = (ex < 0) ? 16'h8000 : 16'h7FFF;
`else
                    res[r][c] = 16'(ex);
`endif
                end else begin
                    res[r][c] = 16'(ex);
                end
            end
        end
    endfunction

    function automatic mat_t fill_mat(input logic [W-1:0] v);
        mat_t m;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                m[r][c] = v;
        return m;
    endfunction

    function automatic mat_t rand_mat();
        mat_t m;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                m[r][c] = 16'($urandom);
        return m;
    endfunction

    function automatic mat_t matmul(input mat_t a, input mat_t b);
        mat_t m;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                logic [W-1:0] acc;
                acc = 16'd0;
                for (int k = 0; k < N; k++) acc = acc + a[r][k] * b[k][c];
                m[r][c] = acc;
            end
        end
        return m;
    endfunction

    // Raise startAdd, keep it for 'hold' edges, report edges from launch to endAdd (-1 on timeout).
    task automatic do_op(input int hold, output int lat);
        lat = -1;
        startAdd = 1'b1;
        for (int cyc = 0; cyc < 40 && lat < 0; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc + 1 >= hold) startAdd = 1'b0;
            if (endAdd === 1'b1) lat = cyc;
        end
    endtask

    initial begin
        mat_t exp_m;
        mat_t a0;
        mat_t b0;
        mat_t q_m;
        mat_t p_m;
        logic exp_ov;
        int   lat;
        int   edges;
        logic seen_end;

        rst = 1'b1;
        startAdd = 1'b0;
        subtract = 1'b0;
        A = '0;
        B = '0;
        step(3);
        check("reset_res", Res, '0);
        check("reset_end", endAdd, 1'b0);
        check("reset_ovf", ovf, 1'b0);
        rst = 1'b0;
        step(2);

        // Test 1: plain add, start held for several cycles.
        A = fill_mat(16'd7);
        B = fill_mat(16'd3);
        subtract = 1'b0;
        do_op(5, lat);
        check("t1_latency", lat, 16);
        check("t1_res_const", Res, fill_mat(16'd10));
        check("t1_ovf", ovf, 1'b0);
        step(4);
        check("t1_end_hold", endAdd, 1'b1);
        check("t1_res_hold", Res, fill_mat(16'd10));

        // Test 2: subtract to a negative result.
        A = fill_mat(16'd5);
        B = fill_mat(16'd9);
        subtract = 1'b1;
        do_op(1, lat);
        check("t2_latency", lat, 16);
        check("t2_res", Res, fill_mat(16'hFFFC));
        check("t2_ovf", ovf, 1'b0);

        // Test 3: single-element positive overflow, then a clean operation clears ovf.
        A = '0;
        B = '0;
        A[0][0] = 16'h7FFF;
        B[0][0] = 16'h0001;
        subtract = 1'b0;
        do_op(2, lat);
`ifdef MAT_ADD_SAT_EN
        check("t3_res00", Res[0][0], 16'h7FFF);
`else
        check("t3_res00", Res[0][0], 16'h8000);
`endif
        check("t3_res_rest", Res[3][3], 16'h0000);
        check("t3_ovf", ovf, 1'b1);
        A[0][0] = 16'h0100;
        do_op(1, lat);
        check("t3_clean_res00", Res[0][0], 16'h0101);
        check("t3_clean_ovf", ovf, 1'b0);

        // Test 4: reset in the middle of RUN aborts with no endAdd.
        A = rand_mat();
        B = rand_mat();
        subtract = 1'b0;
        startAdd = 1'b1;
        step(1);
        startAdd = 1'b0;
        step(8);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("t4_abort_end", endAdd, 1'b0);
        check("t4_abort_res", Res, '0);
        check("t4_abort_ovf", ovf, 1'b0);
        seen_end = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (endAdd === 1'b1) seen_end = 1'b1;
        end
        check("t4_no_late_end", seen_end, 1'b0);
        model(A, B, 1'b0, exp_m, exp_ov);
        do_op(1, lat);
        check("t4_restart_latency", lat, 16);
        check("t4_restart_res", Res, exp_m);
        check("t4_restart_ovf", ovf, exp_ov);

        // Test 5: second start edge during RUN ignored; operand change after launch has no effect.
        a0 = rand_mat();
        b0 = rand_mat();
        A = a0;
        B = b0;
        subtract = 1'b1;
        model(a0, b0, 1'b1, exp_m, exp_ov);
        startAdd = 1'b1;
        step(1);
        startAdd = 1'b0;
        step(3);
        B = rand_mat();
        subtract = 1'b0;
        step(2);
        startAdd = 1'b1;
        step(1);
        startAdd = 1'b0;
        edges = 6;
        lat = -1;
        for (int i = 0; i < 40 && lat < 0; i++) begin
            step(1);
            edges++;
            if (endAdd === 1'b1) lat = edges;
        end
        check("t5_latency", lat, 16);
        check("t5_res_snapshot", Res, exp_m);
        check("t5_ovf", ovf, exp_ov);
        seen_end = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (endAdd === 1'b1) seen_end = 1'b1;
        end
        check("t5_single_op", Res, exp_m);
        check("t5_end_held", endAdd, 1'b1);
        startAdd = 1'b1;
        step(1);
        startAdd = 1'b0;
        check("t5_relaunch_clears_end", endAdd, 1'b0);
        step(20);

        // startAdd held through reset release launches on the first edge after reset.
        rst = 1'b1;
        startAdd = 1'b1;
        A = rand_mat();
        B = rand_mat();
        subtract = 1'b0;
        step(2);
        model(A, B, 1'b0, exp_m, exp_ov);
        rst = 1'b0;
        do_op(30, lat);
        check("rstrel_latency", lat, 16);
        check("rstrel_res", Res, exp_m);
        startAdd = 1'b0;
        step(2);

        // Test 6: chained behind a multiplier model, endMult held high drives startAdd.
        a0 = rand_mat();
        b0 = rand_mat();
        q_m = rand_mat();
        p_m = matmul(matmul(a0, b0), rand_mat());
        B = q_m;
        subtract = 1'b0;
        step(10);
        A = p_m;
        model(p_m, q_m, 1'b0, exp_m, exp_ov);
        do_op(40, lat);
        check("t6_latency", lat, 16);
        check("t6_chain_res", Res, exp_m);
        check("t6_chain_ovf", ovf, exp_ov);
        startAdd = 1'b0;
        step(2);

        // Random operations with random hold lengths.
        for (int k = 0; k < 6; k++) begin
            A = rand_mat();
            B = rand_mat();
            subtract = 1'($urandom);
            model(A, B, subtract, exp_m, exp_ov);
            do_op(int'($urandom_range(1, 20)), lat);
            check("rand_latency", lat, 16);
            check("rand_res", Res, exp_m);
            check("rand_ovf", ovf, exp_ov);
            step(int'($urandom_range(1, 4)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
